pipe_adder: RTL and testbench

- Parametrised, pipelined ripple adder. It is the successor of the fixed 32-bit two-segment adder.
- Splits WIDTH-bit operands into NSEG = WIDTH/SEG segments and adds one segment per pipeline stage, passing the carry stage to stage.
- Valid/ready handshake on input and output; throughput of one operation per cycle.
- Sits in the datapath wherever a wide add must meet timing at high clock rates.

---
 rtl/pipe_adder_pkg.sv | 29 ++
 rtl/pipe_adder_seg_add.sv | 27 ++
 rtl/pipe_adder.sv | 139 +++++++++++++
 tb/tb_pipe_adder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared constants, stage sizing helpers and the stage record
// used by the pipelined segment adder.
package pipe_adder_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SEG   = 16;

   // Number of pipeline stages for a given operand width and segment size.
   function automatic int calc_nseg(input int width, input int seg);
      return width / seg;
   endfunction

   // A configuration is legal when the operand splits into whole segments.
   function automatic bit seg_cfg_ok(input int width, input int seg);
      return (seg > 0) && (width >= seg) && ((width % seg) == 0);
   endfunction

   // Stage record at the default width. The top module declares the same
   // layout sized by its own WIDTH parameter.
   typedef struct packed {
      logic                 valid;
      logic                 carry;
      logic [DEF_WIDTH-1:0] sum;
      logic [DEF_WIDTH-1:0] a_rem;
      logic [DEF_WIDTH-1:0] b_rem;
      logic [1:0]           msbs;   // {a msb, effective b msb}
   } stage_t;

endpackage

// File: rtl/pipe_adder_seg_add.sv
// seg_add: SEG-bit combinational ripple-carry adder with carry in and out.
module seg_add #(
   parameter int SEG = 16
) (
   input  logic [SEG-1:0] i_a,
   input  logic [SEG-1:0] i_b,
   input  logic           i_cin,
   output logic [SEG-1:0] o_sum,
   output logic           o_cout
);

   logic [SEG:0] w_c;

   // Bitwise ripple: each bit produces its sum and passes its carry upward.
   always_comb begin
      w_c    = '0;
      o_sum  = '0;
      w_c[0] = i_cin;
      for (int i = 0; i < SEG; i++) begin
         o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
         w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
      end
   end

   assign o_cout = w_c[SEG];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined ripple adder, one SEG-bit segment per stage, with
// valid/ready on both sides and one beat per cycle throughput.
// Optional subtract mode is compiled in with PIPE_ADDER_SUB_EN.
//
// Handshake: a beat moves across a boundary on a rising edge where the
// producer's valid and the consumer's ready are both high; valid never
// depends on ready, and a presented beat holds stable until taken.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEG   = DEF_SEG
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSEG = calc_nseg(WIDTH, SEG);

   if (!seg_cfg_ok(WIDTH, SEG)) begin : g_bad_cfg
      $error("pipe_adder: WIDTH must be a non-zero multiple of SEG");
   end

   typedef struct packed {
      logic             valid;
      logic             carry;
      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] a_rem;
      logic [WIDTH-1:0] b_rem;
      logic [1:0]       msbs;   // {a msb, effective b msb}
   } stage_rec_t;

   stage_rec_t                r_stg [NSEG];
   stage_rec_t                w_src [NSEG];
   stage_rec_t                w_nxt [NSEG];
   logic [NSEG-1:0]           w_load;
   logic [NSEG-1:0]           w_adv;
   logic [NSEG-1:0][SEG-1:0]  w_seg_sum;
   logic [NSEG-1:0]           w_seg_co;
   logic                      w_sub;
   logic [WIDTH-1:0]          w_b_eff;
   logic                      w_cin_eff;
   logic                      w_unused_tail;

`ifdef PIPE_ADDER_SUB_EN
   assign w_sub = sub;
`else
   assign w_sub = 1'b0;
`endif

   // Subtraction is a + ~b + 1; cin is ignored in that mode.
   assign w_b_eff   = w_sub ? ~b : b;
   assign w_cin_eff = w_sub ? 1'b1 : cin;

   // Ready chain: the last stage drains on out_ready, each earlier stage
   // advances when the next one can load.
   always_comb begin
      w_adv  = '0;
      w_load = '0;
      w_adv[NSEG-1]  = r_stg[NSEG-1].valid && out_ready;
      w_load[NSEG-1] = !r_stg[NSEG-1].valid || w_adv[NSEG-1];
      for (int k = NSEG - 2; k >= 0; k--) begin
         w_adv[k]  = r_stg[k].valid && w_load[k+1];
         w_load[k] = !r_stg[k].valid || w_adv[k];
      end
   end

   assign in_ready = w_load[0];

   // Stage inputs: stage 0 sees the operand beat, later stages the previous register.
   always_comb begin
      w_src[0].valid = in_valid;
      w_src[0].carry = w_cin_eff;
      w_src[0].sum   = '0;
      w_src[0].a_rem = a;
      w_src[0].b_rem = w_b_eff;
      w_src[0].msbs  = {a[WIDTH-1], w_b_eff[WIDTH-1]};
      for (int k = 1; k < NSEG; k++) begin
         w_src[k] = r_stg[k-1];
      end
   end

   for (genvar k = 0; k < NSEG; k++) begin : g_seg
      seg_add #(.SEG(SEG)) u_seg_add (
         .i_a    (w_src[k].a_rem[k*SEG +: SEG]),
         .i_b    (w_src[k].b_rem[k*SEG +: SEG]),
         .i_cin  (w_src[k].carry),
         .o_sum  (w_seg_sum[k]),
         .o_cout (w_seg_co[k])
      );
   end

   // Next record per stage: pass everything along, fill in this stage's segment.
   always_comb begin
      for (int k = 0; k < NSEG; k++) begin
         w_nxt[k]                   = w_src[k];
         w_nxt[k].sum[k*SEG +: SEG] = w_seg_sum[k];
         w_nxt[k].carry             = w_seg_co[k];
      end
   end

   // Stage registers load whenever their slot is free or being vacated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NSEG; k++) begin
            r_stg[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NSEG; k++) begin
            if (w_load[k]) begin
               r_stg[k] <= w_nxt[k];
            end
         end
      end
   end

   assign out_valid = r_stg[NSEG-1].valid;
   assign sum       = r_stg[NSEG-1].sum;
   assign cout      = r_stg[NSEG-1].carry;
   assign ovf       = (r_stg[NSEG-1].msbs[1] == r_stg[NSEG-1].msbs[0]) &&
                      (r_stg[NSEG-1].sum[WIDTH-1] != r_stg[NSEG-1].msbs[1]);

   // Operands are fully consumed by the time they reach the last stage.
   assign w_unused_tail = ^{r_stg[NSEG-1].a_rem, r_stg[NSEG-1].b_rem};

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed and random checks of pipe_adder at 32/16 and 64/8.
module tb_pipe_adder;

  localparam int NSEG_N = 2;
  localparam int NSEG_W = 8;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // narrow (32/16) and wide (64/8) interfaces
  logic        in_valid, in_ready, cin, out_valid, cout, ovf;
  logic [31:0] a, b, sum;
  logic        w_in_valid, w_in_ready, w_cin, w_out_valid, w_cout, w_ovf;
  logic [63:0] w_a, w_b, w_sum;
  logic        tb_sub;
  logic        out_ready;
  int          rdy_mode;

  pipe_adder #(.WIDTH(32), .SEG(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef PIPE_ADDER_SUB_EN
    .sub(tb_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipe_adder #(.WIDTH(64), .SEG(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .cin(w_cin),
`ifdef PIPE_ADDER_SUB_EN
    .sub(tb_sub),
`endif
    .out_valid(w_out_valid), .out_ready(out_ready),
    .sum(w_sum), .cout(w_cout), .ovf(w_ovf)
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {ovf, cout, sum} for a w-bit add (w <= 64), sum in the low bits.
  function automatic logic [65:0] ref_add(input logic [63:0] ra, input logic [63:0] rb,
                                          input logic rc, input logic rs, input int w);
    logic [63:0] mask, beff;
    logic [64:0] full;
    logic        ci, co, am, bm, sm;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    beff = (rs ? ~rb : rb) & mask;
    ci   = rs ? 1'b1 : rc;
    full = {1'b0, ra & mask} + {1'b0, beff} + {64'd0, ci};
    co   = full[w];
    am   = ra[w-1];
    bm   = beff[w-1];
    sm   = full[w-1];
    return {(am == bm) && (sm != am), co, full[63:0] & mask};
  endfunction

  // ---------------- scoreboards ----------------
  logic [33:0] exp_q[$];
  logic [65:0] exp_w_q[$];
  logic        hold_n, hold_w;
  logic [34:0] held_n;
  logic [66:0] held_w;

  // Narrow monitor: outputs and handshakes are stable at the falling edge.
  always @(negedge clk) begin
    logic [65:0] r;
    logic [33:0] e;
    if (!rst_n) begin
      hold_n = 1'b0;
    end else begin
      chk("n_in_ready", in_ready, ((exp_q.size() < NSEG_N) || out_ready));
      if (hold_n) chk("n_hold_stable", {out_valid, ovf, cout, sum}, held_n);
      if (exp_q.size() == 0) begin
        chk("n_spurious_out", out_valid, 1'b0);
      end else if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        chk("n_result", {ovf, cout, sum}, e);
      end
      hold_n = out_valid && !out_ready;
      held_n = {out_valid, ovf, cout, sum};
      if (in_valid && in_ready) begin
        r = ref_add({32'd0, a}, {32'd0, b}, cin, tb_sub, 32);
        exp_q.push_back({r[65:64], r[31:0]});
      end
    end
  end

  // Wide monitor.
  always @(negedge clk) begin
    logic [65:0] e;
    if (!rst_n) begin
      hold_w = 1'b0;
    end else begin
      chk("w_in_ready", w_in_ready, ((exp_w_q.size() < NSEG_W) || out_ready));
      if (hold_w) chk("w_hold_stable", {w_out_valid, w_ovf, w_cout, w_sum}, held_w);
      if (exp_w_q.size() == 0) begin
        chk("w_spurious_out", w_out_valid, 1'b0);
      end else if (w_out_valid && out_ready) begin
        e = exp_w_q.pop_front();
        chk("w_result", {w_ovf, w_cout, w_sum}, e);
      end
      hold_w = w_out_valid && !out_ready;
      held_w = {w_out_valid, w_ovf, w_cout, w_sum};
      if (w_in_valid && w_in_ready) exp_w_q.push_back(ref_add(w_a, w_b, w_cin, tb_sub, 64));
    end
  end

  // out_ready driver: 0 steady high, 1 toggle, 2 steady low, 3 random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc, input logic ts);
    int n = 0;
    a = ta; b = tb_v; cin = tc; tb_sub = ts; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("n_send_accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] ta, input logic [63:0] tb_v, input logic tc, input logic ts);
    int n = 0;
    w_a = ta; w_b = tb_v; w_cin = tc; tb_sub = ts; w_in_valid = 1'b1;
    @(negedge clk);
    while (!w_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("w_send_accept", w_in_ready, 1'b1);
    @(posedge clk);
    #1;
    w_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_w_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size() + exp_w_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; rdy_mode = 0; out_ready = 1'b1; tb_sub = 1'b0;
    in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b1;
    w_in_valid = 1'b1; w_a = 64'h1; w_b = 64'h2; w_cin = 1'b0;

    // Reset with in_valid held: outputs stay cleared.
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_sum", sum, 32'h0);
      chk("rst_cout", cout, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_w_out_valid", w_out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0; w_in_valid = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_w_in_ready", w_in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Carry across the segment boundary; result one edge after acceptance.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    chk("lat_not_yet", out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_valid", out_valid, 1'b1);
    chk("wrap_sum", sum, 32'h0000_0000);
    chk("wrap_cout", cout, 1'b1);
    chk("wrap_ovf", ovf, 1'b0);
    wait_drain();

    // Signed overflow and carry-in propagation.
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    wait_drain();

`ifdef PIPE_ADDER_SUB_EN
    send(32'd5, 32'd7, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("sub_sum", sum, 32'hFFFF_FFFE);
    chk("sub_cout", cout, 1'b0);
    wait_drain();
    tb_sub = 1'b0;
`endif

    // Back-to-back beats under a 1,0,1,0 out_ready pattern.
    out_ready = 1'b0;
    rdy_mode  = 1;
    for (int i = 0; i < 8; i++) begin
      send(32'(i), 32'(16 * i), 1'b0, 1'b0);
    end
    rdy_mode = 0;
    wait_drain();

    // Reset with two beats in flight: out_valid drops at once, nothing follows.
    rdy_mode = 2; out_ready = 1'b0;
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    send(32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("full_in_ready", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    exp_q.delete();
    exp_w_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1; rdy_mode = 0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_no_out", out_valid, 1'b0);

    // Random sweep on the 64/8 instance with random back-pressure.
    rdy_mode = 3;
    for (int i = 0; i < 300; i++) begin
`ifdef PIPE_ADDER_SUB_EN
      send_w({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
`else
      send_w({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
`endif
    end
    send_w(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    send_w(64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    rdy_mode = 0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
